// File: rtl/hamming_pkg.sv
// Shared widths, types and codeword bit positions for the (8,4) Hamming encoder.
package hamming_pkg;

   localparam int NIBBLE_W = 4;
   localparam int CW_W     = 8;

   // Codeword bit positions: parity bits P1..P4, data bits D1..D4
   localparam int P1 = 0;
   localparam int P2 = 1;
   localparam int D1 = 2;
   localparam int P3 = 3;
   localparam int D2 = 4;
   localparam int D3 = 5;
   localparam int D4 = 6;
   localparam int P4 = 7;

   typedef logic [NIBBLE_W-1:0] nibble_t;
   typedef logic [CW_W-1:0]     cw_t;

endpackage

// File: rtl/hamming_enc_comb.sv
// Purely combinational (8,4) Hamming encoder: nibble in, codeword out.
module hamming_enc_comb
   import hamming_pkg::*;
(
   input  nibble_t nibble,
   output cw_t     codeword
);

   always_comb begin
      codeword     = '0;
      codeword[P1] = nibble[0] ^ nibble[1] ^ nibble[3];
      codeword[P2] = nibble[0] ^ nibble[2] ^ nibble[3];
      codeword[D1] = nibble[0];
      codeword[P3] = nibble[1] ^ nibble[2] ^ nibble[3];
      codeword[D2] = nibble[1];
      codeword[D3] = nibble[2];
      codeword[D4] = nibble[3];
      codeword[P4] = nibble[0] ^ nibble[1] ^ nibble[2];
   end

endmodule

// File: rtl/hamming_enc_arbiter.sv
// Round-robin arbiter sharing one Hamming encoder between NREQ nibble sources,
// with a small registered output FIFO tagged by source ID.
module hamming_enc_arbiter
   import hamming_pkg::*;
#(
   parameter  int NREQ       = 4,
   parameter  int FIFO_DEPTH = 2,
   localparam int IDW        = $clog2(NREQ)
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NIBBLE_W*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]            req_ready,
   output logic                       out_valid,
   output logic [CW_W-1:0]            out_data,
   output logic [IDW-1:0]             out_src,
   input  logic                       out_ready,
   output logic                       busy,
   output logic [15:0]                enc_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [IDW-1:0] src;
      cw_t            cw;
   } entry_t;

   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   grant_idx;
   logic [IDW-1:0]   scan_idx;
   logic             grant_found;
   logic             fifo_room;
   logic             accept;
   logic             pop;
   nibble_t          grant_nibble;
   cw_t              grant_cw;
   entry_t           mem [FIFO_DEPTH];
   entry_t           last_head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_count;

   // First valid requester at or after rr_ptr, wrapping modulo NREQ
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = IDW'((int'(rr_ptr) + k) % NREQ);
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // Space check uses the pre-pop count, so a full FIFO never grants even when popping
   assign fifo_room    = fifo_count < CNT_W'(FIFO_DEPTH);
   assign accept       = grant_found & fifo_room;
   assign req_ready    = accept ? (NREQ'(1) << grant_idx) : '0;
   assign grant_nibble = req_data[int'(grant_idx)*NIBBLE_W +: NIBBLE_W];

   hamming_enc_comb u_enc (
      .nibble   (grant_nibble),
      .codeword (grant_cw)
   );

   assign out_valid = (fifo_count != '0);
   assign busy      = out_valid;
   assign pop       = out_valid & out_ready;
   assign out_data  = out_valid ? mem[rd_ptr].cw  : last_head.cw;
   assign out_src   = out_valid ? mem[rd_ptr].src : last_head.src;

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= '{src: grant_idx, cw: grant_cw};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         enc_count  <= '0;
         last_head  <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            enc_count <= enc_count + 16'd1;
            last_head <= mem[rd_ptr];
         end
         case ({accept, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// Scoreboard bench for hamming_enc_arbiter: a cycle model predicts grants and
// queues expected codewords, which are compared as the DUT delivers them.
module tb_hamming_enc_arbiter;

   localparam int NREQ  = 4;
   localparam int DEPTH = 2;

   logic             clk;
   logic             rstn;
   logic [NREQ-1:0]  req_valid;
   logic [4*NREQ-1:0] req_data;
   logic [NREQ-1:0]  req_ready;
   logic             out_valid;
   logic [7:0]       out_data;
   logic [1:0]       out_src;
   logic             out_ready;
   logic             busy;
   logic [15:0]      enc_count;

   hamming_enc_arbiter #(.NREQ(NREQ), .FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .busy      (busy),
      .enc_count (enc_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] src;
      logic [7:0] cw;
   } exp_t;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_enc(input logic [3:0] d);
      logic [7:0] c;
      c[0] = d[0] ^ d[1] ^ d[3];
      c[1] = d[0] ^ d[2] ^ d[3];
      c[2] = d[0];
      c[3] = d[1] ^ d[2] ^ d[3];
      c[4] = d[1];
      c[5] = d[2];
      c[6] = d[3];
      c[7] = d[0] ^ d[1] ^ d[2];
      return c;
   endfunction

   // Reference model state
   int         m_rr, m_cnt, m_pops, m_eg, m_idx;
   logic [15:0] m_enc;
   exp_t       m_last;
   logic       m_pop;
   logic [NREQ-1:0] m_ready;
   bit         wrap_done = 1'b0;

   always @(negedge clk) begin
      if (!rstn) begin
         sb.delete();
         m_rr = 0; m_cnt = 0; m_pops = 0; m_enc = '0; m_last = '0;
         check_val("rst_out_valid", out_valid, 0);
         check_val("rst_busy", busy, 0);
         check_val("rst_enc_count", enc_count, 0);
         check_val("rst_out_data", out_data, 0);
         check_val("rst_out_src", out_src, 0);
      end else begin
         if (m_pops == 65536 && !wrap_done) begin
            check_val("enc_count_wrap", enc_count, 16'h0000);
            wrap_done = 1'b1;
         end
         check_val("enc_count", enc_count, m_enc);
         check_val("out_valid", out_valid, m_cnt != 0);
         check_val("busy", busy, m_cnt != 0);
         m_eg = -1;
         if (m_cnt < DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
               m_idx = (m_rr + k) % NREQ;
               if (m_eg < 0 && req_valid[m_idx]) m_eg = m_idx;
            end
         end
         m_ready = (m_eg >= 0) ? NREQ'(1 << m_eg) : '0;
         check_val("req_ready", req_ready, m_ready);
         if (m_cnt != 0) begin
            check_val("out_data", out_data, sb[0].cw);
            check_val("out_src", out_src, sb[0].src);
         end else begin
            check_val("idle_out_data", out_data, m_last.cw);
            check_val("idle_out_src", out_src, m_last.src);
         end
         m_pop = (m_cnt != 0) && out_ready;
         if (m_pop) begin
            m_last = sb.pop_front();
            m_enc  = m_enc + 16'd1;
            m_pops++;
         end
         if (m_eg >= 0) begin
            sb.push_back('{src: 2'(m_eg), cw: ref_enc(req_data[m_eg*4 +: 4])});
            m_rr = (m_eg + 1) % NREQ;
         end
         m_cnt = m_cnt + ((m_eg >= 0) ? 1 : 0) - (m_pop ? 1 : 0);
      end
   end

   task automatic send(input int idx, input logic [3:0] nib);
      int n;
      n = 0;
      req_data[idx*4 +: 4] = nib;
      req_valid[idx] = 1'b1;
      @(negedge clk);
      while (!req_ready[idx] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check_val("send_timeout", 0, 1);
      @(posedge clk);
      #1 req_valid[idx] = 1'b0;
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #1 rstn = 1'b0;
      @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   initial begin
      int accepts;
      int n;
      logic [NREQ-1:0] acc;
      rstn = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      // Single requester 0, nibble 1011
      out_ready = 1'b1;
      req_data[3:0] = 4'b1011;
      req_valid = 4'b0001;
      @(negedge clk);
      check_val("t1_ready", req_ready, 4'b0001);
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      check_val("t1_valid", out_valid, 1);
      check_val("t1_data", out_data, 8'h55);
      check_val("t1_src", out_src, 0);
      @(negedge clk);
      check_val("t1_count", enc_count, 1);

      // Encoder sweep from requester 2
      for (int v = 0; v < 16; v++) begin
         send(2, 4'(v));
         @(negedge clk);
         if (v == 0)  check_val("enc_0", out_data, 8'h00);
         if (v == 1)  check_val("enc_1", out_data, 8'h87);
         if (v == 15) check_val("enc_f", out_data, 8'hFF);
         @(posedge clk);
         #1;
      end
      repeat (3) @(posedge clk);

      // Round robin with all requesters valid and no backpressure
      reset_pulse();
      req_data  = 16'h9C3A;
      req_valid = 4'hF;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check_val("rr_grant", req_ready, 1 << (k % 4));
         if (k > 0) check_val("rr_src", out_src, (k - 1) % 4);
         @(posedge clk);
         #1;
      end
      req_valid = '0;
      repeat (3) @(posedge clk);

      // Backpressure: only DEPTH accepts, then drain and resume
      #1 out_ready = 1'b0;
      req_valid = 4'hF;
      accepts = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (req_ready != '0) accepts++;
         @(posedge clk);
         #1;
      end
      check_val("bp_accepts", accepts, DEPTH);
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1 req_valid = '0;
      repeat (3) @(posedge clk);

      // Reset with two entries queued
      #1 out_ready = 1'b0;
      req_valid = 4'hF;
      repeat (2) @(posedge clk);
      #1 req_valid = '0;
      check_val("pre_rst_busy", busy, 1);
      rstn = 1'b0;
      #1;
      check_val("mid_rst_valid", out_valid, 0);
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_count", enc_count, 0);
      @(posedge clk);
      #1 rstn = 1'b1;
      req_valid = 4'b1010;
      @(negedge clk);
      check_val("post_rst_grant", req_ready, 4'b0010);
      @(posedge clk);
      #1 req_valid = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);

      // Random traffic honouring the hold-until-accepted rule
      acc = '0;
      for (int c = 0; c < 300; c++) begin
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || acc[i]) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               req_data[i*4 +: 4] = 4'($urandom);
            end
         end
         out_ready = ($urandom % 4) != 0;
         @(negedge clk);
         acc = req_ready & req_valid;
         @(posedge clk);
      end
      #1 req_valid = '0;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);

      // 65536 pops wrap enc_count
      reset_pulse();
      req_data[3:0] = 4'h9;
      req_valid = 4'b0001;
      out_ready = 1'b1;
      n = 0;
      while (!wrap_done && n < 70000) begin
         @(posedge clk);
         n++;
      end
      if (!wrap_done) check_val("wrap_timeout", 0, 1);
      #1 req_valid = '0;
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
